// File: rtl/useq_ctrl.sv
// useq_ctrl - microsequencer driving the micro-program counter (MPC).
//
// Each cycle in RUN the sequencing code of the current microinstruction is
// decoded and the MPC load controls are driven combinationally, so the MPC
// advances on the same edge (one microinstruction per cycle).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   run_i                 start pulse (leaves IDLE/HALT, MPC cleared to 0)
//   upc_i                 current MPC value
//   uop_ctrl_i/cond_i/inv_i/addr_i  next-address field of the microinstruction
//   flags_i               {V,N,C,Z} registered ALU flags
//   map_addr_i, ir_valid_i, ir_ready_o  opcode dispatch handshake
//   loop_ld_i, loop_val_i loop counter load (LOOP_CNT_EN builds only)
//   mpc_en_o, mpc_sel_o, mpc_in_o, mpc_next_o  MPC controls
//   running_o, halted_o, stack_err_o           status
//
// Optional build macro: LOOP_CNT_EN adds an 8-bit loop counter that replaces
// the N flag as condition 11 of CJMP.
//
// state  | meaning
// IDLE   | after reset, waiting for run
// RUN    | executing, one microinstruction per cycle
// MAPW   | waiting for ir_valid to dispatch an opcode
// HALT   | stopped by HALT code or stack fault, waiting for run
module useq_ctrl #(
   parameter int AW    = 16,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          run_i,
   input  logic [AW-1:0] upc_i,
   input  logic [2:0]    uop_ctrl_i,
   input  logic [1:0]    uop_cond_i,
   input  logic          uop_inv_i,
   input  logic [AW-1:0] uop_addr_i,
   input  logic [3:0]    flags_i,
   input  logic [AW-1:0] map_addr_i,
   input  logic          ir_valid_i,
   output logic          ir_ready_o,
   input  logic          loop_ld_i,
   input  logic [7:0]    loop_val_i,
   output logic          mpc_en_o,
   output logic [1:0]    mpc_sel_o,
   output logic [AW-1:0] mpc_in_o,
   output logic [AW-1:0] mpc_next_o,
   output logic          running_o,
   output logic          halted_o,
   output logic          stack_err_o
);

   localparam int SPW = $clog2(DEPTH) + 1;

   localparam logic [2:0] C_NEXT  = 3'b000;
   localparam logic [2:0] C_JMP   = 3'b001;
   localparam logic [2:0] C_CJMP  = 3'b010;
   localparam logic [2:0] C_CALL  = 3'b011;
   localparam logic [2:0] C_RET   = 3'b100;
   localparam logic [2:0] C_MAP   = 3'b101;
   localparam logic [2:0] C_FETCH = 3'b110;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_MAPW, S_HALT} state_t;

   state_t           state_q, state_d;
   logic [SPW-1:0]   sp_q, sp_d;
   logic             err_q, err_d;
   logic [AW-1:0]    stack_q [DEPTH];
   logic             push;
   logic             cond;
   logic [AW-1:0]    upc_inc;
   logic [SPW-2:0]   tos_idx;

   assign upc_inc = upc_i + AW'(1);
   // sp counts entries, so the top of stack lives one below it
   assign tos_idx = sp_q[SPW-2:0] - (SPW-1)'(1);

`ifdef LOOP_CNT_EN
   logic [7:0] cnt_q, cnt_d;
   logic       loop_dec;
   logic       unused_ok;
   assign unused_ok = flags_i[3];

   always_comb begin
      cnt_d = cnt_q;
      if (loop_ld_i)     cnt_d = loop_val_i;
      else if (loop_dec) cnt_d = cnt_q - 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= 8'd0;
      else        cnt_q <= cnt_d;
   end
`else
   logic unused_ok;
   assign unused_ok = ^{flags_i[3], loop_ld_i, loop_val_i};
`endif

   always_comb begin
      cond = 1'b1;
      case (uop_cond_i)
         2'b01:   cond = flags_i[0];
         2'b10:   cond = flags_i[1];
`ifdef LOOP_CNT_EN
         2'b11:   cond = (cnt_q != 8'd0);
`else
         2'b11:   cond = flags_i[2];
`endif
         default: cond = 1'b1;
      endcase
      cond = cond ^ uop_inv_i;
   end

   always_comb begin
      state_d    = state_q;
      sp_d       = sp_q;
      err_d      = err_q;
      push       = 1'b0;
      mpc_en_o   = 1'b0;
      mpc_sel_o  = 2'b00;
      mpc_in_o   = '0;
      ir_ready_o = 1'b0;
      mpc_next_o = (state_q == S_RUN) ? upc_inc : '0;
`ifdef LOOP_CNT_EN
      loop_dec   = 1'b0;
`endif
      case (state_q)
         S_IDLE, S_HALT: begin
            if (run_i) begin
               mpc_en_o = 1'b1;
               sp_d     = '0;
               err_d    = 1'b0;
               state_d  = S_RUN;
            end
         end
         S_MAPW: begin
            if (ir_valid_i) begin
               ir_ready_o = 1'b1;
               mpc_en_o   = 1'b1;
               mpc_sel_o  = 2'b11;
               mpc_in_o   = map_addr_i;
               state_d    = S_RUN;
            end
         end
         default: begin
            case (uop_ctrl_i)
               C_NEXT: begin
                  mpc_en_o  = 1'b1;
                  mpc_sel_o = 2'b10;
               end
               C_JMP: begin
                  mpc_en_o  = 1'b1;
                  mpc_sel_o = 2'b11;
                  mpc_in_o  = uop_addr_i;
               end
               C_CJMP: begin
                  mpc_en_o  = 1'b1;
                  mpc_sel_o = cond ? 2'b11 : 2'b10;
                  mpc_in_o  = cond ? uop_addr_i : '0;
`ifdef LOOP_CNT_EN
                  loop_dec  = (uop_cond_i == 2'b11) && (cnt_q != 8'd0);
`endif
               end
               C_CALL: begin
                  if (sp_q == SPW'(DEPTH)) begin
                     err_d   = 1'b1;
                     state_d = S_HALT;
                  end else begin
                     push      = 1'b1;
                     sp_d      = sp_q + SPW'(1);
                     mpc_en_o  = 1'b1;
                     mpc_sel_o = 2'b11;
                     mpc_in_o  = uop_addr_i;
                  end
               end
               C_RET: begin
                  if (sp_q == '0) begin
                     err_d   = 1'b1;
                     state_d = S_HALT;
                  end else begin
                     sp_d      = sp_q - SPW'(1);
                     mpc_en_o  = 1'b1;
                     mpc_sel_o = 2'b11;
                     mpc_in_o  = stack_q[tos_idx];
                  end
               end
               C_MAP: begin
                  if (ir_valid_i) begin
                     ir_ready_o = 1'b1;
                     mpc_en_o   = 1'b1;
                     mpc_sel_o  = 2'b11;
                     mpc_in_o   = map_addr_i;
                  end else begin
                     state_d = S_MAPW;
                  end
               end
               C_FETCH: begin
                  mpc_en_o = 1'b1;
               end
               default: state_d = S_HALT;
            endcase
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sp_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sp_q    <= sp_d;
         err_q   <= err_d;
      end
   end

   // stack contents survive reset; only sp is cleared
   always_ff @(posedge clk) begin
      if (push) stack_q[sp_q[SPW-2:0]] <= upc_inc;
   end

   assign running_o   = (state_q == S_RUN) || (state_q == S_MAPW);
   assign halted_o    = (state_q == S_HALT);
   assign stack_err_o = err_q;

endmodule

// File: tb/tb_useq_ctrl.sv
module tb_useq_ctrl;
   localparam int DEPTH = 4;
   localparam int M_IDLE = 0, M_RUN = 1, M_MAPW = 2, M_HALT = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run_i;
   logic [15:0] upc_i;
   logic [2:0]  uop_ctrl_i;
   logic [1:0]  uop_cond_i;
   logic        uop_inv_i;
   logic [15:0] uop_addr_i;
   logic [3:0]  flags_i;
   logic [15:0] map_addr_i;
   logic        ir_valid_i;
   logic        ir_ready_o;
   logic        loop_ld_i;
   logic [7:0]  loop_val_i;
   logic        mpc_en_o;
   logic [1:0]  mpc_sel_o;
   logic [15:0] mpc_in_o;
   logic [15:0] mpc_next_o;
   logic        running_o, halted_o, stack_err_o;

   useq_ctrl #(.AW(16), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .run_i(run_i), .upc_i(upc_i),
      .uop_ctrl_i(uop_ctrl_i), .uop_cond_i(uop_cond_i), .uop_inv_i(uop_inv_i),
      .uop_addr_i(uop_addr_i), .flags_i(flags_i), .map_addr_i(map_addr_i),
      .ir_valid_i(ir_valid_i), .ir_ready_o(ir_ready_o),
      .loop_ld_i(loop_ld_i), .loop_val_i(loop_val_i),
      .mpc_en_o(mpc_en_o), .mpc_sel_o(mpc_sel_o), .mpc_in_o(mpc_in_o),
      .mpc_next_o(mpc_next_o), .running_o(running_o), .halted_o(halted_o),
      .stack_err_o(stack_err_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // behavioural model state
   int          m_st;
   logic [15:0] m_stack[$];
   bit          m_err;
   logic [15:0] m_mpc;
   int          m_cnt;
   // per-cycle expectations and pending updates
   logic        e_en, e_rdy;
   logic [1:0]  e_sel;
   logic [15:0] e_in, e_next;
   int          n_st, n_cnt;
   bit          n_err, do_push, do_pop, do_clr;

   typedef struct {
      logic [2:0]  ctrl;
      logic [1:0]  cond;
      logic        inv;
      logic [15:0] addr;
      logic [3:0]  flags;
      logic [15:0] upc;
      logic        en;
      logic [1:0]  sel;
      logic [15:0] in_;
      logic [15:0] nxt;
   } vec_t;
   vec_t tbl[12];

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit cond_of(logic [1:0] c, logic [3:0] f, logic inv, int cnt);
      bit r;
      case (c)
         2'b00:   r = 1'b1;
         2'b01:   r = f[0];
         2'b10:   r = f[1];
`ifdef LOOP_CNT_EN
         default: r = (cnt != 0);
`else
         default: r = f[2];
`endif
      endcase
      return r ^ inv;
   endfunction

   task automatic dispatch();
      e_rdy = 1; e_en = 1; e_sel = 2'b11; e_in = map_addr_i; n_st = M_RUN;
   endtask

   task automatic model_eval();
      e_en = 0; e_sel = 0; e_in = 0; e_next = 0; e_rdy = 0;
      n_st = m_st; n_err = m_err; do_push = 0; do_pop = 0; do_clr = 0;
      n_cnt = m_cnt;
      if (m_st == M_IDLE || m_st == M_HALT) begin
         if (run_i) begin e_en = 1; n_st = M_RUN; do_clr = 1; n_err = 0; end
      end else if (m_st == M_MAPW) begin
         if (ir_valid_i) dispatch();
      end else begin
         e_next = upc_i + 16'd1;
         case (uop_ctrl_i)
            3'd0: begin e_en = 1; e_sel = 2'b10; end
            3'd1: begin e_en = 1; e_sel = 2'b11; e_in = uop_addr_i; end
            3'd2: begin
               e_en = 1;
               if (cond_of(uop_cond_i, flags_i, uop_inv_i, m_cnt)) begin
                  e_sel = 2'b11; e_in = uop_addr_i;
               end else e_sel = 2'b10;
               if (uop_cond_i == 2'b11 && m_cnt > 0) n_cnt = m_cnt - 1;
            end
            3'd3: begin
               if (m_stack.size() == DEPTH) begin n_err = 1; n_st = M_HALT; end
               else begin do_push = 1; e_en = 1; e_sel = 2'b11; e_in = uop_addr_i; end
            end
            3'd4: begin
               if (m_stack.size() == 0) begin n_err = 1; n_st = M_HALT; end
               else begin do_pop = 1; e_en = 1; e_sel = 2'b11; e_in = m_stack[$]; end
            end
            3'd5: if (ir_valid_i) dispatch(); else n_st = M_MAPW;
            3'd6: e_en = 1;
            default: n_st = M_HALT;
         endcase
      end
`ifdef LOOP_CNT_EN
      if (loop_ld_i) n_cnt = loop_val_i;
`else
      n_cnt = 0;
`endif
   endtask

   // evaluate model, compare at the falling edge
   task automatic cyc_a(string name);
      model_eval();
      @(negedge clk);
      check(name,
            {mpc_en_o, mpc_sel_o, ir_ready_o, running_o, halted_o, stack_err_o, mpc_in_o, mpc_next_o},
            {e_en, e_sel, e_rdy, (m_st == M_RUN || m_st == M_MAPW), (m_st == M_HALT), m_err, e_in, e_next});
   endtask

   // clock edge: commit model state and present the new MPC value
   task automatic cyc_b();
      @(posedge clk);
      if (do_clr) m_stack.delete();
      if (do_push) m_stack.push_back(upc_i + 16'd1);
      if (do_pop) void'(m_stack.pop_back());
      m_err = n_err;
      m_st  = n_st;
      m_cnt = n_cnt;
      if (e_en) m_mpc = (e_sel == 2'b11) ? e_in : (e_sel == 2'b10) ? e_next : 16'h0;
      #1;
      upc_i = m_mpc;
   endtask

   task automatic cyc(string name);
      cyc_a(name);
      cyc_b();
   endtask

   task automatic model_reset();
      m_st = M_IDLE; m_stack.delete(); m_err = 0; m_mpc = 0; m_cnt = 0;
   endtask

   task automatic set_uop(logic [2:0] c, logic [1:0] cd, logic inv, logic [15:0] a);
      uop_ctrl_i = c; uop_cond_i = cd; uop_inv_i = inv; uop_addr_i = a;
   endtask

   initial begin
      rst_n = 0; run_i = 0; upc_i = 0; flags_i = 0; map_addr_i = 0; ir_valid_i = 0;
      loop_ld_i = 0; loop_val_i = 0;
      set_uop(3'd0, 2'b00, 1'b0, 16'h0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outputs",
            {mpc_en_o, mpc_sel_o, ir_ready_o, running_o, halted_o, stack_err_o, mpc_in_o, mpc_next_o},
            39'h0);
      @(posedge clk); #1;
      rst_n = 1;

      // run pulse, then straight-line execution
      run_i = 1;
      cyc("run_from_idle");
      run_i = 0;
      repeat (3) cyc("next_seq");

      // decode table (state stays RUN throughout)
      tbl[0]  = '{3'd0, 2'b00, 1'b0, 16'h0000, 4'b0000, 16'h0005, 1'b1, 2'b10, 16'h0000, 16'h0006};
      tbl[1]  = '{3'd0, 2'b00, 1'b0, 16'h0000, 4'b0000, 16'hFFFF, 1'b1, 2'b10, 16'h0000, 16'h0000};
      tbl[2]  = '{3'd1, 2'b00, 1'b0, 16'h1234, 4'b0000, 16'h0007, 1'b1, 2'b11, 16'h1234, 16'h0008};
      tbl[3]  = '{3'd2, 2'b01, 1'b0, 16'h0040, 4'b0001, 16'h0010, 1'b1, 2'b11, 16'h0040, 16'h0011};
      tbl[4]  = '{3'd2, 2'b01, 1'b0, 16'h0040, 4'b1110, 16'h0010, 1'b1, 2'b10, 16'h0000, 16'h0011};
      tbl[5]  = '{3'd2, 2'b01, 1'b1, 16'h0040, 4'b0001, 16'h0010, 1'b1, 2'b10, 16'h0000, 16'h0011};
      tbl[6]  = '{3'd2, 2'b01, 1'b1, 16'h0040, 4'b0000, 16'h0010, 1'b1, 2'b11, 16'h0040, 16'h0011};
      tbl[7]  = '{3'd2, 2'b10, 1'b0, 16'h0777, 4'b0010, 16'h0020, 1'b1, 2'b11, 16'h0777, 16'h0021};
      tbl[8]  = '{3'd2, 2'b11, 1'b0, 16'h0888, 4'b1011, 16'h0022, 1'b1, 2'b10, 16'h0000, 16'h0023};
`ifdef LOOP_CNT_EN
      tbl[9]  = '{3'd2, 2'b11, 1'b0, 16'h0999, 4'b0100, 16'h0024, 1'b1, 2'b10, 16'h0000, 16'h0025};
`else
      tbl[9]  = '{3'd2, 2'b11, 1'b0, 16'h0999, 4'b0100, 16'h0024, 1'b1, 2'b11, 16'h0999, 16'h0025};
`endif
      tbl[10] = '{3'd2, 2'b00, 1'b1, 16'h0ABC, 4'b1111, 16'h0030, 1'b1, 2'b10, 16'h0000, 16'h0031};
      tbl[11] = '{3'd6, 2'b00, 1'b0, 16'h0DEF, 4'b0000, 16'h0033, 1'b1, 2'b00, 16'h0000, 16'h0034};
      for (int i = 0; i < 12; i++) begin
         set_uop(tbl[i].ctrl, tbl[i].cond, tbl[i].inv, tbl[i].addr);
         flags_i = tbl[i].flags;
         upc_i   = tbl[i].upc;
         @(negedge clk);
         check($sformatf("tbl%0d", i), {mpc_en_o, mpc_sel_o, mpc_in_o, mpc_next_o, running_o},
               {tbl[i].en, tbl[i].sel, tbl[i].in_, tbl[i].nxt, 1'b1});
         @(posedge clk); #1;
      end
      m_mpc = 16'h0; flags_i = 0;

      // CALL then RET
      m_mpc = 16'h0010; upc_i = m_mpc;
      set_uop(3'd3, 2'b00, 1'b0, 16'h0100);
      cyc("call");
      set_uop(3'd4, 2'b00, 1'b0, 16'h0000);
      cyc_a("ret");
      check("ret_target", mpc_in_o, 16'h0011);
      cyc_b();

      // nested CALLs overflow the stack
      for (int i = 0; i < 5; i++) begin
         set_uop(3'd3, 2'b00, 1'b0, 16'h0200 + 16'(i * 16));
         cyc("nested_call");
      end
      set_uop(3'd0, 2'b00, 1'b0, 16'h0);
      cyc_a("after_overflow");
      check("ovf_state", {halted_o, stack_err_o, mpc_en_o}, 3'b110);
      cyc_b();

      // restart from HALT clears the error
      run_i = 1;
      cyc("run_from_halt");
      run_i = 0;
      cyc_a("restart_status");
      check("restart_flags", {running_o, stack_err_o, upc_i}, {1'b1, 1'b0, 16'h0000});
      cyc_b();

      // RET on empty stack
      set_uop(3'd4, 2'b00, 1'b0, 16'h0);
      cyc("ret_underflow");
      set_uop(3'd0, 2'b00, 1'b0, 16'h0);
      run_i = 1;
      cyc("run_after_underflow");
      run_i = 0;

      // MAP with delayed ir_valid
      set_uop(3'd5, 2'b00, 1'b0, 16'h0);
      map_addr_i = 16'h0200;
      for (int i = 0; i < 3; i++) begin
         cyc_a("map_wait");
         check("map_wait_en", {mpc_en_o, ir_ready_o}, 2'b00);
         cyc_b();
         set_uop(3'd0, 2'b00, 1'b0, 16'h0);
      end
      ir_valid_i = 1;
      cyc_a("map_dispatch");
      check("map_dispatch_out", {ir_ready_o, mpc_sel_o, mpc_in_o}, {1'b1, 2'b11, 16'h0200});
      cyc_b();
      ir_valid_i = 0;
      cyc_a("map_done");
      check("map_ready_pulse", ir_ready_o, 1'b0);
      cyc_b();

      // MAP with ir_valid already high dispatches at once
      set_uop(3'd5, 2'b00, 1'b0, 16'h0);
      ir_valid_i = 1; map_addr_i = 16'h0345;
      cyc("map_immediate");
      ir_valid_i = 0;

      // HALT code
      set_uop(3'd7, 2'b00, 1'b0, 16'h0);
      cyc("halt_code");
      set_uop(3'd0, 2'b00, 1'b0, 16'h0);
      cyc_a("halted");
      check("halted_flag", {halted_o, running_o, mpc_en_o}, 3'b100);
      cyc_b();
      ir_valid_i = 1;
      cyc("halt_ignores_ir");
      ir_valid_i = 0;
      run_i = 1;
      cyc("run_from_halt2");
      run_i = 0;

      // reset while waiting in MAPW
      set_uop(3'd5, 2'b00, 1'b0, 16'h0);
      cyc("enter_mapw");
      ir_valid_i = 1;
      #1;
      rst_n = 0;
      #1;
      check("rst_mapw", {ir_ready_o, running_o, mpc_en_o}, 3'b000);
      @(posedge clk); #1;
      rst_n = 1; ir_valid_i = 0;
      model_reset(); upc_i = m_mpc;
      cyc("idle_after_rst");
      run_i = 1;
      cyc("run_after_rst");
      run_i = 0;

`ifdef LOOP_CNT_EN
      set_uop(3'd0, 2'b00, 1'b0, 16'h0);
      loop_ld_i = 1; loop_val_i = 8'd3;
      cyc("loop_load");
      loop_ld_i = 0;
      for (int i = 0; i < 4; i++) begin
         set_uop(3'd2, 2'b11, 1'b0, 16'h0050);
         cyc_a("loop_cjmp");
         check($sformatf("loop_iter%0d", i), mpc_sel_o, (i < 3) ? 2'b11 : 2'b10);
         cyc_b();
      end
`endif

      // randomized run against the model
      for (int i = 0; i < 600; i++) begin
         run_i      = ($urandom_range(0, 7) == 0);
         set_uop(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 16'($urandom));
         flags_i    = 4'($urandom);
         map_addr_i = 16'($urandom);
         ir_valid_i = ($urandom_range(0, 2) == 0);
`ifdef LOOP_CNT_EN
         loop_ld_i  = ($urandom_range(0, 9) == 0);
         loop_val_i = 8'($urandom_range(0, 5));
`endif
         cyc("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/useq_ctrl.md
Name: useq_ctrl

Overview:
- Microsequencer controlling the 16-bit micro-program counter (MPC) register, which holds the current microinstruction address.
- Each cycle it decodes the next-address field of the current microinstruction and drives the MPC's enable, select, jump-target and next-address inputs.
- Supports jumps, condition-flag branches, opcode dispatch with an instruction-register handshake, and a micro-subroutine stack.
- Sits between the control store output, the ALU flag register and the MPC.

Parameters:
AW, 16, microaddress width; matches MPC width.
DEPTH, 4, micro-subroutine stack entries; power of 2, at least 2.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
run  in  1  start pulse: leave IDLE/HALT and begin execution at address 0
upc  in  AW  current MPC value, fed back from the MPC output
uop_ctrl  in  3  sequencing code of the current microinstruction
uop_cond  in  2  condition select: 00 always, 01 Z, 10 C, 11 N (loop count when LOOP_CNT_EN)
uop_inv  in  1  invert the selected condition
uop_addr  in  AW  branch/call target
flags  in  4  {V,N,C,Z}, registered ALU flags
map_addr  in  AW  dispatch address from the opcode map ROM
ir_valid  in  1  instruction register holds a new opcode
ir_ready  out  1  opcode consumed (1-cycle pulse)
loop_ld  in  1  load the loop counter (LOOP_CNT_EN only)
loop_val  in  8  loop counter load value
mpc_en  out  1  MPC enable
mpc_sel  out  2  11 = load mpc_in, 10 = load mpc_next, 00 = clear to 0
mpc_in  out  AW  jump target
mpc_next  out  AW  upc+1, modulo 2^AW
running  out  1  FSM is in RUN or MAPW
halted  out  1  FSM is in HALT
stack_err  out  1  sticky stack over/underflow

Behaviour:
- Reset: FSM=IDLE; stack pointer sp=0; stack_err=0; all outputs 0. The loop counter clears to 0.
- States:
  - IDLE: mpc_en=0. On run, assert mpc_en=1, mpc_sel=00 (MPC cleared to 0) and go to RUN.
  - RUN: each cycle decode uop_ctrl; the MPC is updated on the same clock edge (0-cycle decision latency, 1 microinstruction per cycle).
  - MAPW: waiting for an opcode. mpc_en=0 until ir_valid. The cycle ir_valid=1: ir_ready=1, mpc_sel=11, mpc_in=map_addr, mpc_en=1, go to RUN.
  - HALT: mpc_en=0. run clears stack_err and sp, clears the MPC and goes to RUN.
- Codes in RUN (mpc_next=upc+1 always driven; wrap from all-ones to 0):
  - 000 NEXT: sel=10.
  - 001 JMP: sel=11, mpc_in=uop_addr.
  - 010 CJMP: cond = selected flag XOR uop_inv. If cond, sel=11 with mpc_in=uop_addr; else sel=10.
  - 011 CALL: push upc+1 and jump to uop_addr. If sp==DEPTH: no push, set stack_err, mpc_en=0, go to HALT.
  - 100 RET: pop; sel=11, mpc_in=top of stack. If sp==0: set stack_err, go to HALT.
  - 101 MAP: if ir_valid this cycle, dispatch immediately as in MAPW; otherwise mpc_en=0 and go to MAPW.
  - 110 FETCH: sel=00 (MPC cleared to 0).
  - 111 HALT: mpc_en=0, go to HALT.
- ir_ready is asserted only when a dispatch actually occurs. It is never asserted in IDLE or HALT.
- run while in RUN or MAPW is ignored.
- Reset asserted mid-operation returns everything to the reset values immediately; stack contents are not cleared, only sp.
- uop_* inputs are sampled only in RUN.

Optional Feature:
LOOP_CNT_EN
- Defined:
  - 8-bit loop counter; loop_ld loads loop_val (any state).
  - CJMP with uop_cond=11: cond = (count!=0) XOR uop_inv.
  - When count!=0 the counter decrements in the same cycle. If loop_ld is also asserted, the load wins.
- Undefined:
  - No counter logic; uop_cond=11 selects the N flag.
  - loop_ld and loop_val are ignored.

Test Plan:
1. Reset, then run pulse with all uop_ctrl=000 -> mpc_sel=00 once, then sel=10 with mpc_next=upc+1 each cycle; upc=16'hFFFF gives mpc_next=0.
2. CJMP, uop_cond=01, uop_addr=16'h0040: with Z=1 -> sel=11, mpc_in=16'h0040. With Z=0 -> sel=10. With uop_inv=1 the two outcomes are reversed.
3. CALL at upc=16'h0010 to 16'h0100, then RET -> mpc_in=16'h0011. Five nested CALLs (DEPTH=4) -> stack_err=1, halted=1, mpc_en=0.
4. MAP with ir_valid=0 for 3 cycles, then 1 with map_addr=16'h0200 -> mpc_en=0 for 3 cycles; then ir_ready=1 for exactly one cycle with mpc_sel=11, mpc_in=16'h0200.
5. HALT code -> halted=1; later run -> MPC cleared, stack_err=0, running=1. Reset asserted while in MAPW -> IDLE, ir_ready=0.
6. (LOOP_CNT_EN) loop_ld with loop_val=3, then CJMP uop_cond=11 repeated -> jumps taken 3 times, counter reaches 0, fourth CJMP falls through with sel=10.
